nibble_seq_adder: RTL and testbench
===================================

Name: nibble_seq_adder

Overview:
- Multi-cycle add/subtract sequencer that reuses one 4-bit full-adder slice to produce a WIDTH-bit result.
- Processes one nibble per cycle, LSB first, rippling the carry through a register.
- Sits between an operand producer and a result consumer, using valid/ready handshakes on both sides.
- Replaces a wide combinational adder where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8. NNIB = WIDTH/4.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand set {a, b, sub} is valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A-B.
- out_valid  output  1  result and flags are valid (high only in DONE).
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference.
- carry  output  1  carry-out of the MSB nibble; for sub, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  result == 0.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst high at a clock edge): state = IDLE, nibble index = 0, carry register = 0, result = 0.
  - Outputs after reset: carry = 0, overflow = 0, zero = 0, out_valid = 0, in_ready = 1, busy = 0.
  - Reset mid-RUN or mid-DONE aborts the operation; no result is ever presented for it.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1 (acceptance edge T0): latch a; latch b_eff = sub ? ~b : b; carry register = sub; index = 0; go to RUN.
- RUN:
  - Each edge adds nibble[idx] of a and b_eff plus the carry register through the 4-bit slice.
  - Writes the 4-bit sum into result[4*idx+3 : 4*idx] and stores the nibble carry-out.
  - At idx == NNIB-1, also captures carry-in and carry-out of the MSB bit, then goes to DONE; otherwise idx increments.
  - in_valid is ignored while in RUN (in_ready = 0).
- DONE:
  - out_valid = 1.
  - result, carry, overflow and zero are held stable until an edge with out_ready=1; that edge returns to IDLE.
- Latency:
  - out_valid rises after edge T0+NNIB (4 cycles for WIDTH=16).
  - Minimum issue interval is NNIB+2 cycles; there is no bypass from DONE directly to accepting new operands.
- Flags:
  - overflow = carry into MSB bit XOR carry out of MSB bit.
  - zero is computed from the final result register contents.
  - result wraps modulo 2^WIDTH.
  - carry and overflow read 0 outside DONE; zero reads 0 outside DONE.
- Simultaneous in_valid and out_ready in DONE: only the result handshake completes. New operands are accepted on the following IDLE cycle.

Optional Feature:
- Macro: NIBBLE_SEQ_SAT_EN.
- Defined:
  - When overflow=1 at completion, result is replaced in DONE by signed saturation.
  - The MSB of a selects the clamp: MSB 0 gives 0x7F..F; MSB 1 gives 0x80..0.
  - overflow still reads 1; carry is unchanged.
  - zero is evaluated on the saturated value.
  - Saturation adds no cycles.
- Undefined: result always wraps; no saturation logic is present.

Test Plan:
- WIDTH=16, add 0x1234 + 0x4321 -> result 0x5555, carry 0, overflow 0, zero 0; out_valid rises exactly 4 cycles after the acceptance edge; in_ready is 0 from T0 until DONE exits.
- add 0xFFFF + 0x0001 -> result 0x0000, carry 1, zero 1, overflow 0.
- add 0x7FFF + 0x0001 -> result 0x8000, overflow 1, carry 0; with NIBBLE_SEQ_SAT_EN -> result 0x7FFF, overflow 1.
- sub 0x0005 - 0x0007 -> result 0xFFFE, carry 0, overflow 0; sub 0x8000 - 0x0001 -> result 0x7FFF, carry 1, overflow 1; with NIBBLE_SEQ_SAT_EN -> result 0x8000.
- out_ready held 0 for 10 cycles in DONE -> result and flags are constant, out_valid stays 1; in_valid pulses during RUN and DONE are not accepted.
- rst pulsed for one cycle during RUN nibble 2 -> next cycle in_ready=1, out_valid=0, result=0, busy=0; a following add completes with correct values.

Source files
------------

// File: rtl/nibble_seq_adder.sv
// Add/subtract sequencer that reuses one 4-bit adder slice, one nibble per cycle, LSB first.
// Latency: out_valid rises NNIB cycles after the acceptance edge; issue interval is NNIB+2 cycles.
// Backpressure: result and flags stay in DONE until out_ready; in_ready is high only in IDLE.
// Optional NIBBLE_SEQ_SAT_EN: on signed overflow the result is clamped to the signed limit.
module nibble_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);
    localparam int NNIB = WIDTH / 4;
    localparam int IW   = $clog2(NNIB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [IW-1:0]    idx;
    logic             cy_reg;
    logic             ovf_reg;

    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       low3;
    logic [4:0]       full;
    logic             ovf_now;
    logic             last;

    // 4-bit slice; the 3-bit partial sum exposes the carry into the MSB bit.
    always_comb begin
        nib_a   = a_reg[{idx, 2'b00} +: 4];
        nib_b   = b_reg[{idx, 2'b00} +: 4];
        low3    = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b000, cy_reg};
        full    = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, cy_reg};
        ovf_now = low3[3] ^ full[4];
        last    = (idx == IW'(NNIB - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
        result    = res_reg;
        carry     = (state == DONE) && cy_reg;
        overflow  = (state == DONE) && ovf_reg;
        zero      = (state == DONE) && (res_reg == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            idx     <= '0;
            cy_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= sub ? ~b : b;
                        cy_reg  <= sub;
                        idx     <= '0;
                        ovf_reg <= 1'b0;
                    end
                end
                RUN: begin
                    res_reg[{idx, 2'b00} +: 4] <= full[3:0];
                    cy_reg                     <= full[4];
                    if (last) begin
                        ovf_reg <= ovf_now;
`ifdef NIBBLE_SEQ_SAT_EN
                        // Clamp direction follows the sign of A, which both operands share on overflow.
                        if (ovf_now) begin
                            res_reg <= a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                      : {1'b0, {(WIDTH-1){1'b1}}};
                        end
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_seq_adder.sv
// Scoreboard bench for nibble_seq_adder (WIDTH=16): directed vectors, monitor pops on result handshake.
module tb_nibble_seq_adder;
    localparam int WIDTH = 16;
    localparam int NNIB  = WIDTH / 4;
`ifdef NIBBLE_SEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic             z;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    nibble_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares on every result handshake, independent of the stimulus.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0h expected=none at %0t", result, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("result",   result,   mon_e.r);
                chk("carry",    carry,    mon_e.c);
                chk("overflow", overflow, mon_e.v);
                chk("zero",     zero,     mon_e.z);
            end
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic xs, input exp_t e, input bit hold);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        a         = xa;
        b         = xb;
        sub       = xs;
        in_valid  = 1'b1;
        out_ready = !hold;
        @(posedge clk);
        sb.push_back(e);
        #1;
        if (hold) begin
            a  = ~xa;
            b  = ~xb;
        end else begin
            in_valid = 1'b0;
        end
        for (int k = 1; k <= NNIB; k++) begin
            @(posedge clk);
            #1;
            chk("out_valid_latency", out_valid, (k == NNIB));
            chk("in_ready_busy", in_ready, 0);
            chk("busy", busy, 1);
        end
        if (hold) begin
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                #1;
                chk("hold_out_valid", out_valid, 1);
                chk("hold_result",    result,    e.r);
                chk("hold_carry",     carry,     e.c);
                chk("hold_overflow",  overflow,  e.v);
                chk("hold_zero",      zero,      e.z);
                chk("hold_in_ready",  in_ready,  0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_result",    result,    0);
        chk("rst_carry",     carry,     0);
        chk("rst_overflow",  overflow,  0);
        chk("rst_zero",      zero,      0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h1234, 16'h4321, 1'b0, '{16'h5555, 1'b0, 1'b0, 1'b0}, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1}, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0,
               '{(SAT ? 16'h7FFF : 16'h8000), 1'b0, 1'b1, 1'b0}, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0}, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1,
               '{(SAT ? 16'h8000 : 16'h7FFF), 1'b1, 1'b1, 1'b0}, 1'b0);
        run_op(16'h1234, 16'h1234, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0,
               '{(SAT ? 16'h8000 : 16'h0000), 1'b1, 1'b1, !SAT}, 1'b0);
        run_op(16'h00FF, 16'h0F01, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0}, 1'b1);

        // Abort: reset lands on the edge that would process nibble 2.
        @(negedge clk);
        a        = 16'h9876;
        b        = 16'h1111;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready",  in_ready,  1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result",    result,    0);
        chk("abort_busy",      busy,      0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'hA5A5, 16'h1111, 1'b0, '{16'hB6B6, 1'b0, 1'b0, 1'b0}, 1'b0);

        repeat (8) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end
endmodule
